fetch_aligner: RTL and testbench

//  Instruction-fetch aligner for the RV32IC pipeline; sits between instruction memory and IF/ID register.

---
 rtl/fetch_aligner.sv | 138 +++++++++++++
 tb/tb_fetch_aligner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_aligner.sv
// RV32IC fetch aligner: turns word-aligned fetch words into one 32-bit or 16-bit
// instruction per handshake, carrying a spare upper halfword across fetches.
module fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter bit          C_EN     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_ir,
   output logic [31:0] out_pc,
   output logic        out_is_c
);

   localparam logic [0:0]  EMPTY = 1'b0;
   localparam logic [0:0]  HALF  = 1'b1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fa_q, fa_d;
   logic [15:0] hold_hw_q, hold_hw_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_ir_q, out_ir_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        out_is_c_q, out_is_c_d;
   logic        advance;
   logic [15:0] lo_hw, hi_hw;

   function automatic logic is_c(input logic [15:0] hw);
      return C_EN && (hw[1:0] != 2'b11);
   endfunction

   assign imem_addr = {fa_q[31:2], 2'b00};
   assign out_valid = out_valid_q;
   assign out_ir    = out_ir_q;
   assign out_pc    = out_pc_q;
   assign out_is_c  = out_is_c_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fa_d        = fa_q;
      hold_hw_d   = hold_hw_q;
      out_valid_d = out_valid_q;
      out_ir_d    = out_ir_q;
      out_pc_d    = out_pc_q;
      out_is_c_d  = out_is_c_q;
      advance     = !out_valid_q || out_ready;
      lo_hw       = imem_rdata[15:0];
      hi_hw       = imem_rdata[31:16];

      if (redirect) begin
         // Pending output is discarded; the consumer flushes it on its side.
         state_d     = EMPTY;
         out_valid_d = 1'b0;
         pc_d        = redirect_pc & (C_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
         fa_d        = {redirect_pc[31:2], 2'b00};
      end else if (advance) begin
         out_valid_d = 1'b0;
         if (state_q == EMPTY) begin
            fa_d = fa_q + 32'd4;
            if (C_EN && pc_q[1]) begin
               if (is_c(hi_hw)) begin
                  out_valid_d = 1'b1;
                  out_ir_d    = {16'h0000, hi_hw};
                  out_pc_d    = pc_q;
                  out_is_c_d  = 1'b1;
                  pc_d        = pc_q + 32'd2;
               end else begin
                  // First half of a misaligned 32-bit instruction: one bubble.
                  hold_hw_d = hi_hw;
                  state_d   = HALF;
               end
            end else if (is_c(lo_hw)) begin
               out_valid_d = 1'b1;
               out_ir_d    = {16'h0000, lo_hw};
               out_pc_d    = pc_q;
               out_is_c_d  = 1'b1;
               pc_d        = pc_q + 32'd2;
               hold_hw_d   = hi_hw;
               state_d     = HALF;
            end else begin
               out_valid_d = 1'b1;
               out_ir_d    = imem_rdata;
               out_pc_d    = pc_q;
               out_is_c_d  = 1'b0;
               pc_d        = pc_q + 32'd4;
            end
         end else begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            if (is_c(hold_hw_q)) begin
               // Buffered compressed instruction needs no memory this cycle.
               out_ir_d   = {16'h0000, hold_hw_q};
               out_is_c_d = 1'b1;
               pc_d       = pc_q + 32'd2;
               state_d    = EMPTY;
            end else begin
               out_ir_d   = {lo_hw, hold_hw_q};
               out_is_c_d = 1'b0;
               pc_d       = pc_q + 32'd4;
               fa_d       = fa_q + 32'd4;
               hold_hw_d  = hi_hw;
               state_d    = HALF;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         pc_q        <= RESET_PC;
         fa_q        <= RESET_PC;
         hold_hw_q   <= 16'h0000;
         out_valid_q <= 1'b0;
         out_ir_q    <= NOP;
         out_pc_q    <= 32'h0000_0000;
         out_is_c_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fa_q        <= fa_d;
         hold_hw_q   <= hold_hw_d;
         out_valid_q <= out_valid_d;
         out_ir_q    <= out_ir_d;
         out_pc_q    <= out_pc_d;
         out_is_c_q  <= out_is_c_d;
      end
   end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: directed vector table, async-reset sequence, then
// randomized traffic against an instruction-stream reference model.
module tb_fetch_aligner;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_ir;
   logic [31:0] out_pc;
   logic        out_is_c;

   logic [31:0] mem [0:63];
   int total = 0;
   int bad   = 0;

   fetch_aligner #(.RESET_PC(32'h0), .C_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .out_ready(out_ready),
      .out_valid(out_valid), .out_ir(out_ir), .out_pc(out_pc), .out_is_c(out_is_c)
   );

   always #5 clk = ~clk;

   assign imem_rdata = (imem_addr[31:8] == 24'h0) ? mem[imem_addr[7:2]] : NOP;

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] eir;
      logic [31:0] epc;
      logic        ec;
      logic [31:0] eaddr;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic rdy, logic redir, logic [31:0] rpc, logic ev,
                               logic [31:0] eir, logic [31:0] epc, logic ec, logic [31:0] eaddr);
      vec_t v;
      v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.ev = ev;
      v.eir = eir; v.epc = epc; v.ec = ec; v.eaddr = eaddr;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the program is a halfword stream; an instruction is one
   // halfword if its low bits are not 2'b11, else two halfwords.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a[31:8] == 24'h0) ? mem[a[7:2]] : NOP;
   endfunction

   function automatic logic [15:0] hw_at(input logic [31:0] a);
      logic [31:0] w;
      w = word_at(a);
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic model_next(input logic [31:0] p, output logic [31:0] ir,
                             output logic c, output logic [31:0] len);
      logic [15:0] h0;
      h0 = hw_at(p);
      if (h0[1:0] != 2'b11) begin
         ir = {16'h0, h0}; c = 1'b1; len = 2;
      end else begin
         ir = {hw_at(p + 32'd2), h0}; c = 1'b0; len = 4;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp_pc, m_ir, m_len;
      logic        m_c;
      logic        stall_prev;
      logic [31:0] p_ir, p_pc, p_addr;
      logic        p_c;
      int          idle;
      logic        r_rdy, r_redir;
      logic [31:0] r_rpc;

      for (int i = 0; i < 64; i++) mem[i] = NOP;
      mem[0] = 32'h00A00093;
      mem[1] = 32'h45854505;
      mem[2] = 32'h00934505;
      mem[3] = 32'h458500A0;

      //   rdy redir rpc          ev ir            pc           c  addr
      add(1, 0, 32'h0,         1, 32'h00A00093, 32'h0,        0, 32'h4);
      add(1, 0, 32'h0,         1, 32'h00004505, 32'h4,        1, 32'h8);
      add(1, 0, 32'h0,         1, 32'h00004585, 32'h6,        1, 32'h8);
      add(1, 0, 32'h0,         1, 32'h00004505, 32'h8,        1, 32'hC);
      add(1, 0, 32'h0,         1, 32'h00A00093, 32'hA,        0, 32'h10);
      add(1, 0, 32'h0,         1, 32'h00004585, 32'hE,        1, 32'h10);
      add(0, 0, 32'h0,         1, 32'h00004585, 32'hE,        1, 32'h10);
      add(0, 0, 32'h0,         1, 32'h00004585, 32'hE,        1, 32'h10);
      add(0, 0, 32'h0,         1, 32'h00004585, 32'hE,        1, 32'h10);
      add(1, 0, 32'h0,         1, 32'h00000013, 32'h10,       0, 32'h14);
      add(1, 1, 32'h6,         0, 32'h0,        32'h0,        0, 32'h4);
      add(1, 0, 32'h0,         1, 32'h00004585, 32'h6,        1, 32'h8);
      add(1, 0, 32'h0,         1, 32'h00004505, 32'h8,        1, 32'hC);
      add(1, 1, 32'hA,         0, 32'h0,        32'h0,        0, 32'h8);
      add(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 32'hC);
      add(1, 0, 32'h0,         1, 32'h00A00093, 32'hA,        0, 32'h10);
      add(1, 0, 32'h0,         1, 32'h00004585, 32'hE,        1, 32'h10);
      add(1, 1, 32'h7,         0, 32'h0,        32'h0,        0, 32'h4);
      add(1, 0, 32'h0,         1, 32'h00004585, 32'h6,        1, 32'h8);
      add(1, 1, 32'hFFFFFFFE,  0, 32'h0,        32'h0,        0, 32'hFFFFFFFC);
      add(1, 0, 32'h0,         1, 32'h00000000, 32'hFFFFFFFE, 1, 32'h0);
      add(1, 0, 32'h0,         1, 32'h00A00093, 32'h0,        0, 32'h4);
      add(1, 0, 32'h0,         1, 32'h00004505, 32'h4,        1, 32'h8);
      add(0, 1, 32'h8,         0, 32'h0,        32'h0,        0, 32'h8);
      add(1, 0, 32'h0,         1, 32'h00004505, 32'h8,        1, 32'hC);

      step();
      step();
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_ir",    out_ir,             NOP);
      chk("rst_pc",    out_pc,             32'h0);
      chk("rst_is_c",  {31'h0, out_is_c},  32'h0);
      chk("rst_addr",  imem_addr,          32'h0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         out_ready   = tbl[i].rdy;
         redirect    = tbl[i].redir;
         redirect_pc = tbl[i].rpc;
         step();
         chk($sformatf("row%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
         if (tbl[i].ev) begin
            chk($sformatf("row%0d_ir", i),   out_ir,            tbl[i].eir);
            chk($sformatf("row%0d_pc", i),   out_pc,            tbl[i].epc);
            chk($sformatf("row%0d_is_c", i), {31'h0, out_is_c}, {31'h0, tbl[i].ec});
         end
         chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
      end
      redirect = 1'b0;

      // Asynchronous reset pulse between edges while a halfword is buffered.
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
      chk("async_rst_addr",  imem_addr,          32'h0);
      chk("async_rst_ir",    out_ir,             NOP);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      step();
      chk("restart_valid", {31'h0, out_valid}, 32'h1);
      chk("restart_ir",    out_ir,             32'h00A00093);
      chk("restart_pc",    out_pc,             32'h0);

      // Randomized traffic over fresh random memory.
      rst = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      step();
      rst = 1'b0;
      exp_pc = 32'h0;
      stall_prev = 1'b0;
      idle = 0;
      p_ir = '0; p_pc = '0; p_addr = '0; p_c = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
         if (stall_prev) begin
            chk("stall_ir",   out_ir,             p_ir);
            chk("stall_pc",   out_pc,             p_pc);
            chk("stall_is_c", {31'h0, out_is_c}, {31'h0, p_c});
            chk("stall_addr", imem_addr,          p_addr);
         end
         r_rdy   = ($urandom_range(0, 3) != 0);
         r_redir = ($urandom_range(0, 15) == 0);
         r_rpc   = $urandom_range(0, 32'hF0);
         if (r_redir) begin
            exp_pc = r_rpc & 32'hFFFF_FFFE;
            idle = 0;
         end else begin
            if (out_valid && r_rdy) begin
               model_next(exp_pc, m_ir, m_c, m_len);
               chk("rand_ir",   out_ir,             m_ir);
               chk("rand_pc",   out_pc,             exp_pc);
               chk("rand_is_c", {31'h0, out_is_c}, {31'h0, m_c});
               exp_pc = exp_pc + m_len;
            end
            if (!out_valid) idle++;
            else idle = 0;
            if (idle > 3) begin
               total++;
               bad++;
               $display("FAIL rand_progress: idle cycles %0d limit 3", idle);
               idle = 0;
            end
         end
         stall_prev = out_valid && !r_rdy && !r_redir;
         p_ir = out_ir; p_pc = out_pc; p_c = out_is_c; p_addr = imem_addr;
         out_ready   = r_rdy;
         redirect    = r_redir;
         redirect_pc = r_rpc;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
